irq_entry_ctrl: RTL

IRQ_ENTRY_CTRL -- requirements
Module: irq_entry_ctrl

---
 rtl/irq_entry_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/irq_entry_ctrl.sv
// irq_entry_ctrl
//   Interrupt entry sequencer. A pending interrupt must present the same
//   offset for STABLE_CYCLES consecutive cycles before it is requested from
//   the core. Once the core acknowledges at a restartable boundary, the
//   block issues one fetch redirect and one mepc/mcause write strobe. It then
//   stays in the handler-active state until mret retires.
//
// Parameters
//   STABLE_CYCLES  cycles irq_offset must hold before a request (1..15)
//
// Ports
//   clk            core clock, rising edge
//   resetn         asynchronous active-low reset
//   irq_any        at least one unmasked interrupt pending
//   irq_offset     index of the highest-priority pending interrupt
//   mie            global interrupt enable
//   mtvec          trap vector: [31:2] base, [1:0] mode (01 = vectored)
//   pipe_pc        PC of the oldest unretired instruction
//   pipe_ready     pipeline is at a restartable boundary
//   irq_ack        core accepted the request and flushed
//   mret_in        mret retirement pulse
//   irq_req        interrupt take request to the core
//   redirect_valid one-cycle fetch redirect strobe
//   irq_target     handler address, valid with redirect_valid
//   mepc_wr        one-cycle mepc/mcause write strobe
//   mepc_val       PC captured at acknowledge
//   mcause_val     {1'b1, 26'b0, latched offset}
//   irq_active     handler in progress
module irq_entry_ctrl #(
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        irq_any,
  input  logic [4:0]  irq_offset,
  input  logic        mie,
  input  logic [31:0] mtvec,
  input  logic [31:0] pipe_pc,
  input  logic        pipe_ready,
  input  logic        irq_ack,
  input  logic        mret_in,
  output logic        irq_req,
  output logic        redirect_valid,
  output logic [31:0] irq_target,
  output logic        mepc_wr,
  output logic [31:0] mepc_val,
  output logic [31:0] mcause_val,
  output logic        irq_active
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    REQ,
    ENTER,
    ACTIVE
  } state_t;

  // SETTLE leaves when the counter equals this value, so the state lasts
  // exactly STABLE_CYCLES cycles, counting from the latch edge.
  localparam logic [3:0] LAST_CNT = 4'(STABLE_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [4:0]  r_offset;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;

  logic        w_take;
  logic        w_pending;
  logic [31:0] w_base;
  logic [31:0] w_vectored;

  assign w_pending = irq_any & mie;
  // The acknowledge only counts while the request is actually visible.
  assign w_take    = irq_ack & pipe_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_offset <= '0;
      r_mepc   <= '0;
      r_mcause <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pending) begin
            r_state  <= SETTLE;
            r_offset <= irq_offset;
            r_cnt    <= '0;
          end
        end
        SETTLE: begin
          if (!w_pending) begin
            r_state <= IDLE;
          end else if (irq_offset != r_offset) begin
            r_offset <= irq_offset;
            r_cnt    <= '0;
          end else if (r_cnt == LAST_CNT) begin
            r_state <= REQ;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        REQ: begin
          // An acknowledge wins over a same-cycle withdrawal of the interrupt.
          if (w_take) begin
            r_state  <= ENTER;
            r_mepc   <= pipe_pc;
            r_mcause <= {1'b1, 26'b0, r_offset};
          end else if (!w_pending) begin
            r_state <= IDLE;
          end
        end
        ENTER: begin
          r_state <= ACTIVE;
        end
        ACTIVE: begin
          if (mret_in) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign w_base     = {mtvec[31:2], 2'b00};
  assign w_vectored = w_base + {25'b0, r_offset, 2'b00};

  assign irq_req        = (r_state == REQ) & pipe_ready;
  assign redirect_valid = (r_state == ENTER);
  assign mepc_wr        = (r_state == ENTER);
  assign irq_active     = (r_state == ACTIVE);
  // mtvec is used live during ENTER; outside ENTER the target reads zero.
  assign irq_target     = (r_state != ENTER)     ? '0 :
                          (mtvec[1:0] == 2'b01) ? w_vectored : w_base;
  assign mepc_val       = r_mepc;
  assign mcause_val     = r_mcause;

endmodule
